// File: rtl/csr_pkg.sv
// Shared constants for the CSR counter bank: address map, Zicsr op encodings,
// counter index assignments and the implemented-bit mask helper.
package csr_pkg;

    localparam int NUM_EVT_MAX = 29;

    localparam int IDX_CYCLE   = 0;
    localparam int IDX_RSVD    = 1;
    localparam int IDX_INSTRET = 2;
    localparam int IDX_EVT0    = 3;

    localparam logic [3:0]  PAGE_CNT_RO  = 4'hC;
    localparam logic [3:0]  PAGE_CNT_RW  = 4'hB;
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_OVF     = 12'h801;
    localparam logic [11:0] ADDR_DSP     = 12'h800;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CNT_RO,
        SEL_CNT_RW,
        SEL_INHIBIT,
        SEL_OVF,
        SEL_DSP
    } csr_sel_e;

    // Bits of the inhibit/overflow registers backed by a real counter.
    function automatic logic [31:0] impl_mask(input int num_evt);
        logic [32:0] m;
        m = (33'd1 << (num_evt + IDX_EVT0)) - 33'd1;
        return m[31:0] & ~(32'd1 << IDX_RSVD);
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_W-bit performance counter with split 32-bit software write access
// and a single-cycle wrap pulse.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             inhibit_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bump;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        bump   = inc_i && !inhibit_i && !wr_lo_i && !wr_hi_i;
        cnt_d  = cnt_q;
        wrap_o = bump && (&cnt_q);
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_W-1:32] = wdata_i[CNT_W-33:0];
        end else if (bump) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_counter_bank.sv
// Execute-stage CSR file: cycle/instret/event counters, inhibit, sticky overflow
// with interrupt, and the DSP mode register. Reads are combinational.
module csr_counter_bank
    import csr_pkg::*;
#(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 64,
    parameter int DSP_MODE_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_valid,
    input  logic [11:0]           csr_addr,
    input  logic [2:0]            csr_funct3,
    input  logic [4:0]            csr_rs1,
    input  logic [4:0]            csr_rd,
    input  logic [31:0]           csr_wdata,
    input  logic [4:0]            csr_zimm,
    input  logic                  instr_retire,
    input  logic [NUM_EVT-1:0]    evt_i,
    output logic [31:0]           csr_rdata,
    output logic                  csr_illegal,
    output logic [DSP_MODE_W-1:0] dsp_mode,
    output logic                  ovf_irq
);

    localparam int          LAST_IDX  = IDX_EVT0 + NUM_EVT - 1;
    localparam logic [31:0] IMPL_MASK = impl_mask(NUM_EVT);

    logic [CNT_W-1:0]      cnt [0:LAST_IDX];
    logic [LAST_IDX:0]     wrap;
    logic [31:0]           inh_q, inh_d, ovf_q, ovf_d;
    logic [DSP_MODE_W-1:0] dsp_q, dsp_d;

    logic             op_ok, src_nz, wen, ren, do_wr, hi_half, cnt_idx_ok;
    logic [4:0]       idx;
    logic [31:0]      mask, old_val, new_val, cnt_hi, dsp_ext, wrap_vec;
    logic [CNT_W-1:0] cnt_sel;
    csr_sel_e         sel;

    always_comb begin
        idx        = csr_addr[4:0];
        hi_half    = csr_addr[7];
        cnt_idx_ok = int'(idx) <= LAST_IDX;
        mask       = csr_funct3[2] ? {27'd0, csr_zimm} : csr_wdata;
        src_nz     = csr_funct3[2] ? (csr_zimm != 5'd0) : (csr_rs1 != 5'd0);

        sel = SEL_NONE;
        if (csr_addr[6:5] == 2'b00 && csr_addr[11:8] == PAGE_CNT_RO) sel = SEL_CNT_RO;
        else if (csr_addr[6:5] == 2'b00 && csr_addr[11:8] == PAGE_CNT_RW) sel = SEL_CNT_RW;
        else if (csr_addr == ADDR_INHIBIT) sel = SEL_INHIBIT;
        else if (csr_addr == ADDR_OVF) sel = SEL_OVF;
        else if (csr_addr == ADDR_DSP) sel = SEL_DSP;

        cnt_sel = '0;
        for (int k = 0; k <= LAST_IDX; k++) begin
            if (idx == 5'(k)) cnt_sel = cnt[k];
        end
        cnt_hi                = '0;
        cnt_hi[CNT_W-33:0]    = cnt_sel[CNT_W-1:32];
        dsp_ext               = '0;
        dsp_ext[DSP_MODE_W-1:0] = dsp_q;

        case (sel)
            SEL_CNT_RO, SEL_CNT_RW: old_val = hi_half ? cnt_hi : cnt_sel[31:0];
            SEL_INHIBIT:            old_val = inh_q;
            SEL_OVF:                old_val = ovf_q;
            SEL_DSP:                old_val = dsp_ext;
            default:                old_val = '0;
        endcase

        op_ok   = 1'b1;
        case (csr_funct3)
            F3_RW, F3_RWI: begin wen = 1'b1;   ren = (csr_rd != 5'd0); new_val = mask;            end
            F3_RS, F3_RSI: begin wen = src_nz; ren = 1'b1;             new_val = old_val | mask;  end
            F3_RC, F3_RCI: begin wen = src_nz; ren = 1'b1;             new_val = old_val & ~mask; end
            default:       begin wen = 1'b0;   ren = 1'b0;             new_val = '0; op_ok = 1'b0; end
        endcase

        // Read-only aliases reject any access that would write, even a no-op value.
        csr_illegal = csr_valid && (!op_ok || sel == SEL_NONE
                      || ((sel == SEL_CNT_RO || sel == SEL_CNT_RW) && !cnt_idx_ok)
                      || (sel == SEL_CNT_RO && wen));
        csr_rdata   = (csr_valid && ren && !csr_illegal) ? old_val : '0;
        do_wr       = csr_valid && wen && !csr_illegal;

        wrap_vec             = '0;
        wrap_vec[LAST_IDX:0] = wrap;

        inh_d = (do_wr && sel == SEL_INHIBIT) ? (new_val & IMPL_MASK) : inh_q;
        // A wrap on the same edge as a software clear keeps the bit set.
        ovf_d = (((do_wr && sel == SEL_OVF) ? new_val : ovf_q) | wrap_vec) & IMPL_MASK;
        dsp_d = (do_wr && sel == SEL_DSP) ? new_val[DSP_MODE_W-1:0] : dsp_q;
    end

    for (genvar k = 0; k <= LAST_IDX; k++) begin : g_cnt
        if (k == IDX_RSVD) begin : g_rsvd
            assign cnt[k]  = '0;
            assign wrap[k] = 1'b0;
        end else begin : g_impl
            logic inc_src;
            if (k == IDX_CYCLE) begin : g_cyc
                assign inc_src = 1'b1;
            end else if (k == IDX_INSTRET) begin : g_ret
                assign inc_src = instr_retire;
            end else begin : g_evt
                assign inc_src = evt_i[k-IDX_EVT0];
            end

            csr_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc_i     (inc_src),
                .inhibit_i (inh_q[k]),
                .wr_lo_i   (do_wr && sel == SEL_CNT_RW && !hi_half && idx == 5'(k)),
                .wr_hi_i   (do_wr && sel == SEL_CNT_RW && hi_half && idx == 5'(k)),
                .wdata_i   (new_val),
                .cnt_o     (cnt[k]),
                .wrap_o    (wrap[k])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inh_q <= '0;
            ovf_q <= '0;
            dsp_q <= '0;
        end else begin
            inh_q <= inh_d;
            ovf_q <= ovf_d;
            dsp_q <= dsp_d;
        end
    end

    assign dsp_mode = dsp_q;
    assign ovf_irq  = |ovf_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank: a behavioural model predicts each
// cycle's outputs, a separate monitor compares them on the falling edge.
module tb_csr_counter_bank;

    localparam int NUM_EVT    = 4;
    localparam int CNT_W      = 64;
    localparam int DSP_MODE_W = 2;
    localparam int LAST       = 2 + NUM_EVT;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               csr_valid;
    logic [11:0]        csr_addr;
    logic [2:0]         csr_funct3;
    logic [4:0]         csr_rs1, csr_rd, csr_zimm;
    logic [31:0]        csr_wdata;
    logic               instr_retire;
    logic [NUM_EVT-1:0] evt_i;
    logic [31:0]        csr_rdata;
    logic               csr_illegal;
    logic [DSP_MODE_W-1:0] dsp_mode;
    logic               ovf_irq;

    csr_counter_bank #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .DSP_MODE_W(DSP_MODE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_valid    (csr_valid),
        .csr_addr     (csr_addr),
        .csr_funct3   (csr_funct3),
        .csr_rs1      (csr_rs1),
        .csr_rd       (csr_rd),
        .csr_wdata    (csr_wdata),
        .csr_zimm     (csr_zimm),
        .instr_retire (instr_retire),
        .evt_i        (evt_i),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .dsp_mode     (dsp_mode),
        .ovf_irq      (ovf_irq)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
    localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

    typedef struct {
        bit          chk;
        bit          csr;
        logic [31:0] rdata;
        bit          illegal;
        logic [1:0]  dsp;
        bit          irq;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    // Architectural state of the model.
    logic [63:0] m_cnt [0:31];
    logic [31:0] m_inh, m_ovf, impl;
    logic [1:0]  m_dsp;

    logic [11:0] addr_tab [0:19] = '{12'hC00, 12'hC02, 12'hC03, 12'hC06, 12'hC07, 12'hC80,
                                     12'hC86, 12'hB00, 12'hB02, 12'hB03, 12'hB06, 12'hB01,
                                     12'hB80, 12'hB83, 12'h320, 12'h801, 12'h800, 12'hC1F,
                                     12'hB87, 12'h123};
    logic [2:0]  f3_tab [0:5] = '{RW, RS, RC, RWI, RSI, RCI};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Drive one cycle, predict its outputs, then advance the model past the edge.
    task automatic step(input bit v, input logic [11:0] a, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [4:0] zi, input bit ret, input logic [NUM_EVT-1:0] ev,
                        input bit rst, input string name);
        exp_t        e;
        int          kind, k, written;
        bit          hi, wen, ren, ill, do_wr, src;
        logic [31:0] mask, old, nv, wraps;

        csr_valid = v; csr_addr = a; csr_funct3 = f3; csr_rs1 = rs1; csr_rd = rd;
        csr_wdata = wd; csr_zimm = zi; instr_retire = ret; evt_i = ev; rst_n = !rst;

        kind = 0; k = 0; hi = 1'b0;
        if (a >= 12'hC00 && a <= 12'hC1F)      begin kind = 1; k = int'(a) - 'hC00; end
        else if (a >= 12'hC80 && a <= 12'hC9F) begin kind = 1; k = int'(a) - 'hC80; hi = 1'b1; end
        else if (a >= 12'hB00 && a <= 12'hB1F) begin kind = 2; k = int'(a) - 'hB00; end
        else if (a >= 12'hB80 && a <= 12'hB9F) begin kind = 2; k = int'(a) - 'hB80; hi = 1'b1; end
        else if (a == 12'h320) kind = 3;
        else if (a == 12'h801) kind = 4;
        else if (a == 12'h800) kind = 5;

        mask = f3[2] ? {27'd0, zi} : wd;
        wen  = (f3[1:0] == 2'b01) || (f3[2] ? (zi != 0) : (rs1 != 0));
        ren  = (f3[1:0] != 2'b01) || (rd != 0);
        case (kind)
            1, 2:    old = (k == 1 || k > LAST) ? 32'd0 : (hi ? m_cnt[k][63:32] : m_cnt[k][31:0]);
            3:       old = m_inh;
            4:       old = m_ovf;
            5:       old = {30'd0, m_dsp};
            default: old = 32'd0;
        endcase
        ill = v && (kind == 0 || f3[1:0] == 2'b00 || (kind <= 2 && k > LAST) || (kind == 1 && wen));
        if (f3[1:0] == 2'b01)      nv = mask;
        else if (f3[1:0] == 2'b10) nv = old | mask;
        else                       nv = old & ~mask;

        e.chk = chk_en; e.csr = v; e.rdata = (v && ren && !ill) ? old : 32'd0;
        e.illegal = ill; e.dsp = m_dsp; e.irq = |m_ovf; e.name = name;
        exp_q.push_back(e);

        if (rst) begin
            for (int j = 0; j < 32; j++) m_cnt[j] = 64'd0;
            m_inh = 0; m_ovf = 0; m_dsp = 0;
        end else begin
            do_wr = v && wen && !ill;
            written = -1;
            wraps = 32'd0;
            if (do_wr && kind == 2) begin
                written = k;
                if (k != 1) begin
                    if (hi) m_cnt[k][63:32] = nv;
                    else    m_cnt[k][31:0]  = nv;
                end
            end
            for (int j = 0; j <= LAST; j++) begin
                if (j == 1 || j == written || m_inh[j]) continue;
                if (j == 0)      src = 1'b1;
                else if (j == 2) src = ret;
                else             src = ev[j-3];
                if (src) begin
                    if (m_cnt[j] == 64'hFFFF_FFFF_FFFF_FFFF) wraps[j] = 1'b1;
                    m_cnt[j] = m_cnt[j] + 64'd1;
                end
            end
            if (do_wr && kind == 4) m_ovf = nv & impl;
            m_ovf = m_ovf | wraps;
            if (do_wr && kind == 3) m_inh = nv & impl;
            if (do_wr && kind == 5) m_dsp = nv[1:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ret, input logic [NUM_EVT-1:0] ev);
        repeat (n) step(1'b0, 12'h0, 3'b0, 5'd0, 5'd0, 32'd0, 5'd0, ret, ev, 1'b0, "idle");
    endtask

    task automatic csr(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] rs1,
                       input logic [4:0] rd, input logic [31:0] wd, input logic [4:0] zi,
                       input string name);
        step(1'b1, a, f3, rs1, rd, wd, zi, 1'b0, '0, 1'b0, name);
    endtask

    task automatic rd_csr(input logic [11:0] a, input string name);
        csr(a, RS, 5'd0, 5'd1, 32'd0, 5'd0, name);
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check({e.name, ".ovf_irq"}, {31'd0, ovf_irq}, {31'd0, e.irq});
                    check({e.name, ".dsp_mode"}, {30'd0, dsp_mode}, {30'd0, e.dsp});
                    if (e.csr) begin
                        check({e.name, ".rdata"}, csr_rdata, e.rdata);
                        check({e.name, ".illegal"}, {31'd0, csr_illegal}, {31'd0, e.illegal});
                    end
                end
            end
        end
    end

    initial begin
        impl = 32'd0;
        for (int j = 0; j <= LAST; j++) if (j != 1) impl[j] = 1'b1;
        for (int j = 0; j < 32; j++) m_cnt[j] = 64'd0;
        m_inh = 0; m_ovf = 0; m_dsp = 0;

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        step(1'b0, 12'h0, 3'b0, 5'd0, 5'd0, 32'd0, 5'd0, 1'b0, '0, 1'b1, "reset0");
        chk_en = 1'b1;
        step(1'b0, 12'h0, 3'b0, 5'd0, 5'd0, 32'd0, 5'd0, 1'b0, '0, 1'b1, "reset1");

        // Cycle counter after ten free-running cycles.
        idle(10, 1'b0, '0);
        rd_csr(12'hC00, "cycle_lo_10");
        rd_csr(12'hC80, "cycle_hi_0");

        // Low-to-high carry on the cycle counter.
        csr(12'hB80, RW, 5'd1, 5'd0, 32'h1, 5'd0, "wr_cycle_hi");
        csr(12'hB00, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "wr_cycle_lo");
        rd_csr(12'hC00, "cycle_lo_ones");
        rd_csr(12'hC00, "cycle_lo_carry");
        rd_csr(12'hC80, "cycle_hi_carry");

        // Event counter 3 wraps, sets overflow; clear and set-wins.
        csr(12'hB03, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "wr_evt3_lo");
        csr(12'hB83, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "wr_evt3_hi");
        step(1'b1, 12'hC03, RS, 5'd0, 5'd1, 32'd0, 5'd0, 1'b0, 4'b0001, 1'b0, "evt3_wrap");
        rd_csr(12'h801, "ovf_after_wrap");
        rd_csr(12'hC83, "evt3_hi_zero");
        csr(12'h801, RC, 5'd1, 5'd0, 32'h8, 5'd0, "ovf_clear");
        idle(1, 1'b0, '0);
        csr(12'hB03, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "wr_evt3_lo2");
        csr(12'hB83, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "wr_evt3_hi2");
        step(1'b1, 12'h801, RC, 5'd1, 5'd0, 32'h8, 5'd0, 1'b0, 4'b0001, 1'b0, "ovf_set_wins");
        rd_csr(12'h801, "ovf_still_set");
        csr(12'h801, RCI, 5'd0, 5'd0, 32'd0, 5'd8, "ovf_clear_imm");

        // Inhibit instret, then release it.
        rd_csr(12'hC02, "instret_before");
        csr(12'h320, RSI, 5'd0, 5'd0, 32'd0, 5'd4, "inhibit_set");
        idle(5, 1'b1, '0);
        rd_csr(12'hC02, "instret_inhibited");
        csr(12'h320, RCI, 5'd0, 5'd0, 32'd0, 5'd4, "inhibit_clr");
        idle(3, 1'b1, '0);
        rd_csr(12'hC02, "instret_plus3");

        // Illegal and edge-legal accesses.
        csr(12'hC00, RW, 5'd1, 5'd0, 32'h5, 5'd0, "ill_ro_write");
        csr(12'hC1F, RW, 5'd1, 5'd0, 32'h5, 5'd0, "ill_idx31");
        csr(12'hC00, RS, 5'd0, 5'd3, 32'h5, 5'd0, "legal_rs_rs1_0");
        csr(12'hB07, RW, 5'd1, 5'd1, 32'h5, 5'd0, "ill_idx7");
        rd_csr(12'hB06, "legal_idx6");
        csr(12'h123, RS, 5'd0, 5'd1, 32'h0, 5'd0, "ill_unmapped");
        csr(12'hB01, RW, 5'd1, 5'd1, 32'h77, 5'd0, "rsvd_write");
        rd_csr(12'hC01, "rsvd_read");
        csr(12'hB00, RW, 5'd1, 5'd0, 32'h0, 5'd0, "rw_rd0");

        // DSP mode, then reset mid-count with everything populated.
        csr(12'h800, RWI, 5'd0, 5'd0, 32'd0, 5'd3, "dsp_write");
        rd_csr(12'h800, "dsp_read");
        csr(12'h320, RW, 5'd1, 5'd0, 32'hFFFF_FFFF, 5'd0, "inhibit_all");
        rd_csr(12'h320, "inhibit_impl_bits");
        csr(12'h320, RW, 5'd1, 5'd0, 32'h0, 5'd0, "inhibit_none");
        idle(3, 1'b1, 4'b1111);
        csr(12'h320, RW, 5'd1, 5'd0, 32'h4, 5'd0, "inhibit_ret");
        step(1'b0, 12'h0, 3'b0, 5'd0, 5'd0, 32'd0, 5'd0, 1'b1, 4'b1111, 1'b1, "mid_reset");
        rd_csr(12'hC02, "post_rst_instret");
        rd_csr(12'hC03, "post_rst_evt3");
        rd_csr(12'h320, "post_rst_inhibit");
        rd_csr(12'h800, "post_rst_dsp");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit          v, ret, rst;
            logic [11:0] a;
            logic [2:0]  f3;
            logic [4:0]  rs1, rd, zi;
            logic [31:0] wd;
            v   = $urandom_range(0, 3) != 0;
            a   = addr_tab[$urandom_range(0, 19)];
            f3  = f3_tab[$urandom_range(0, 5)];
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            zi  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            ret = 1'($urandom_range(0, 1));
            rst = $urandom_range(0, 99) == 0;
            step(v, a, f3, rs1, rd, wd, zi, ret, NUM_EVT'($urandom), rst, "rand");
        end

        idle(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_counter_bank.md
# csr_counter_bank

Parametrised successor to the core's single-counter CSR file. Provides machine-writable cycle, instret and NUM_EVT event counters with per-counter inhibit, sticky overflow status with an interrupt line, illegal-access detection, and a DSP mode register of configurable width. It sits in the execute stage beside the ALU and serves every Zicsr instruction in the same cycle it is issued.

## Interface
- NUM_EVT, 4: number of event counters (hpmcounter3..), range 0..29
- CNT_W, 64: counter width, range 33..64
- DSP_MODE_W, 2: width of the DSP mode register, range 1..32
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- csr_valid  in  1  CSR instruction present this cycle
- csr_addr  in  12  CSR address
- csr_funct3  in  3  Zicsr op (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csr_rs1, csr_rd  in  5 each  register indices (zero suppresses write/read as per Zicsr)
- csr_wdata  in  32  rs1 value; csr_zimm  in  5  immediate
- instr_retire  in  1  one instruction retired this cycle
- evt_i  in  NUM_EVT  per-counter event pulses
- csr_rdata  out  32  old CSR value (combinational)
- csr_illegal  out  1  access illegal (combinational)
- dsp_mode  out  DSP_MODE_W  DSP mode register
- ovf_irq  out  1  OR of sticky overflow bits

## Operation
- Counter index k: 0 cycle, 1 reserved (reads 0, write ignored), 2 instret, 3..2+NUM_EVT event.
- Addresses: 0xC00+k / 0xC80+k read-only low/high aliases; 0xB00+k / 0xB80+k writable low/high; 0x320 inhibit (bit k); 0x801 overflow status (bit k); 0x800 dsp_mode.
- High half reads counter[CNT_W-1:32] zero-extended; writes to high half keep only CNT_W-32 bits.
- Increment source: cycle every clk, instret on instr_retire, event k on evt_i[k-3]; none when inhibit bit k set.
- Write data: RW/RWI value; RS/RSI old|mask; RC/RCI old&~mask; write enable suppressed when rs1==0 (RS/RC) or zimm==0 (RSI/RCI). Read enable suppressed when rd==0 (RW/RWI); csr_rdata=0 when not read-enabled or not valid.
- csr_illegal=1 when valid and: address unmapped, counter index >2+NUM_EVT, or write-enabled access to 0xCxx. Illegal access: no state change, csr_rdata=0.
- Inhibit and overflow registers: implemented bits only (bit 1 and bits above 2+NUM_EVT read 0).
- dsp_mode takes write_data[DSP_MODE_W-1:0].

## Timing
- Reset (rst_n low at clk edge): all counters, inhibit, overflow, dsp_mode = 0; ovf_irq = 0 next cycle.
- Read: zero latency, value sampled before that cycle's update.
- Write: visible on next cycle's read.
- Counter write same cycle as increment: write wins, no increment; writing either half suppresses increment of the whole counter that cycle, the other half is unchanged.
- Wrap: counter at 2^CNT_W-1 incrementing becomes 0 and sets overflow bit k at the same edge; low-half carry into high half occurs in that same increment.
- Overflow bit hardware set and software clear in same cycle: set wins.
- ovf_irq = |overflow register (registered source, no combinational path from inputs).
- Inhibit write takes effect from the following cycle's increment.

## Structure
- Package csr_pkg: address constants, funct3 enum, counter index constants, NUM_EVT max.
- Sub-module csr_counter (one per implemented counter, generate loop): CNT_W register, inc/inhibit, low/high write, wrap pulse out.
- Top holds op decode, address decode, read mux, inhibit, overflow and dsp_mode registers.

## Test plan
- Reset then read 0xC00 with rd!=0 after 10 cycles -> 10; 0xC80 -> 0; csr_illegal=0.
- CSRRW 0xB80=0x1 then CSRRW 0xB00=0xFFFFFFFF, next cycle read 0xC00 -> 0xFFFFFFFF, following -> 0x0 and 0xC80 -> 0x2.
- Write counter 3 (0xB03, 0xB83) to all-ones (CNT_W=64), pulse evt_i[0] -> counter 0, 0x801 bit3=1, ovf_irq=1; CSRRC 0x801 mask 0x8 -> ovf_irq=0.
- CSRRSI 0x320 zimm=0x4, pulse instr_retire 5x -> 0xC02 unchanged; clear inhibit, 3 pulses -> +3.
- CSRRW to 0xC00, and to 0xC1F with NUM_EVT=4 -> csr_illegal=1, no state change; CSRRS 0xC00 rs1=0 -> legal.
- CSRRWI 0x800 zimm=0x3 -> dsp_mode=3 next cycle; rst_n low mid-count -> all registers 0 after that edge.
